// File: rtl/huffman_leaf_state_scanner_pkg.sv
// Shared types and node-word layout for the Huffman tree builder.
// Holds the scanner FSM enum, the node width and field offsets.
package huffman_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_DONE
  } scan_state_e;

  // Node word, MSB to LSB: id, bit, left, right.
  function automatic int node_w(int id_w, int child_w);
    return id_w + 1 + 2 * child_w;
  endfunction

  localparam int RIGHT_OFF = 0;

  function automatic int left_off(int child_w);
    return child_w;
  endfunction

  function automatic int bit_off(int child_w);
    return 2 * child_w;
  endfunction

  function automatic int id_off(int child_w);
    return 2 * child_w + 1;
  endfunction

endpackage

// File: rtl/huffman_leaf_state_scanner_if.sv
// Scan request/result bundle between node table and scanner.
// start/mode/nodes in; busy/done/state/state_valid out.
interface huffman_leaf_state_scanner_if
  import huffman_pkg::*;
#(
  parameter int NODE_COUNT = 7,
  parameter int ID_W       = 4,
  parameter int CHILD_W    = 4,
  parameter int NUM_STATES = 2
);

  localparam int NODE_W = node_w(ID_W, CHILD_W);

  logic                         start;
  logic                         mode;
  logic [NODE_COUNT*NODE_W-1:0] nodes;
  logic                         busy;
  logic                         done;
  logic [NUM_STATES-1:0]        state;
  logic [NUM_STATES-1:0]        state_valid;

  modport master (
    output start, mode, nodes,
    input  busy, done, state, state_valid
  );

  modport slave (
    input  start, mode, nodes,
    output busy, done, state, state_valid
  );

endinterface

// File: rtl/huffman_node_decode.sv
// Combinational node-word decoder.
// node in; is_leaf (left==right), id, code_bit out.
module huffman_node_decode
  import huffman_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int CHILD_W = 4
) (
  input  logic [node_w(ID_W, CHILD_W)-1:0] node,
  output logic                             is_leaf,
  output logic [ID_W-1:0]                  id,
  output logic                             code_bit
);

  assign id       = node[id_off(CHILD_W) +: ID_W];
  assign code_bit = node[bit_off(CHILD_W)];
  assign is_leaf  = node[left_off(CHILD_W) +: CHILD_W]
                 == node[RIGHT_OFF +: CHILD_W];

endmodule

// File: rtl/huffman_leaf_state_scanner.sv
// Walks NODE_COUNT node words, latching leaf code bits per symbol.
// Ports: CLK, nRST (sync, active low), bus (slave modport).
module huffman_leaf_state_scanner
  import huffman_pkg::*;
#(
  parameter int NODE_COUNT = 7,
  parameter int ID_W       = 4,
  parameter int CHILD_W    = 4,
  parameter int NUM_STATES = 2
) (
  input logic                         CLK,
  input logic                         nRST,
  huffman_leaf_state_scanner_if.slave bus
);

  localparam int NODE_W = node_w(ID_W, CHILD_W);
  localparam int IDX_W  =
    (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NODE_COUNT - 1);

  scan_state_e           fsm;
  logic [IDX_W-1:0]      idx;
  logic [NODE_W-1:0]     cap;
  logic                  cap_vld;
  logic                  busy_q;
  logic                  done_q;
  logic [NUM_STATES-1:0] state_q;
  logic [NUM_STATES-1:0] valid_q;

  logic                  is_leaf;
  logic [ID_W-1:0]       id;
  logic                  code_bit;

  huffman_node_decode #(
    .ID_W    (ID_W),
    .CHILD_W (CHILD_W)
  ) u_dec (
    .node     (cap),
    .is_leaf  (is_leaf),
    .id       (id),
    .code_bit (code_bit)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fsm     <= S_IDLE;
      idx     <= '0;
      cap     <= '0;
      cap_vld <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= '0;
      valid_q <= '0;
    end else begin
      // Evaluate runs one cycle behind capture; cap_vld
      // marks a captured word not yet evaluated.
      if (cap_vld && is_leaf) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          if (id == ID_W'(i + 1)) begin
            state_q[i] <= code_bit;
            valid_q[i] <= 1'b1;
          end
        end
      end
      unique case (fsm)
        S_IDLE: begin
          if (bus.start) begin
            fsm    <= S_SCAN;
            idx    <= '0;
            busy_q <= 1'b1;
            if (!bus.mode) begin
              state_q <= '0;
              valid_q <= '0;
            end
          end
        end
        S_SCAN: begin
          cap     <= bus.nodes[int'(idx)*NODE_W +: NODE_W];
          cap_vld <= 1'b1;
          idx     <= idx + 1'b1;
          if (idx == LAST) fsm <= S_FLUSH;
        end
        S_FLUSH: begin
          cap_vld <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          fsm     <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          fsm    <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state       = state_q;
  assign bus.state_valid = valid_q;

endmodule

// File: tb/tb_huffman_leaf_state_scanner.sv
// Directed bench for huffman_leaf_state_scanner.
// Default parameters: 7 nodes, 13-bit node words.
module tb_huffman_leaf_state_scanner;

  localparam int NC = 7;
  localparam int NW = 13;

  logic clk = 1'b0;
  logic nrst;
  int checks = 0;
  int errors = 0;

  huffman_leaf_state_scanner_if #(
    .NODE_COUNT (NC), .ID_W (4),
    .CHILD_W (4), .NUM_STATES (2)
  ) bus ();

  huffman_leaf_state_scanner #(
    .NODE_COUNT (NC), .ID_W (4),
    .CHILD_W (4), .NUM_STATES (2)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [NC*NW-1:0] nv;

  task automatic clear_nodes();
    nv = '0;
    bus.nodes = nv;
  endtask

  task automatic set_node(input int k, input logic [15:0] w);
    nv[k*NW +: NW] = w[NW-1:0];
    bus.nodes = nv;
  endtask

  task automatic chk2(input string nm, input logic [1:0] act,
                      input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts a scan at a negedge; lat = edges from start edge to done.
  task automatic do_scan(input logic m, output int lat,
                         output logic busy_mid);
    bus.start = 1'b1;
    bus.mode  = m;
    lat = -1;
    busy_mid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 1) busy_mid = bus.busy;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    clear_nodes();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    chk2("reset_state", bus.state, 2'b00);
    chk2("reset_valid", bus.state_valid, 2'b00);
    chk_int("reset_busy", int'(bus.busy), 0);
    chk_int("reset_done", int'(bus.done), 0);
  endtask

  task automatic test_basic();
    int lat;
    logic bm;
    clear_nodes();
    set_node(1, 16'h0333);
    set_node(4, 16'h0455);
    do_scan(1'b0, lat, bm);
    chk_int("basic_latency", lat, 8);
    chk_int("basic_busy_mid", int'(bm), 1);
    chk_int("basic_done_pulse", int'(bus.done), 0);
    chk_int("basic_busy_after", int'(bus.busy), 0);
    chk2("basic_state", bus.state, 2'b01);
    chk2("basic_valid", bus.state_valid, 2'b11);
  endtask

  task automatic test_last_wins();
    int lat;
    logic bm;
    clear_nodes();
    set_node(2, 16'h0555);
    set_node(5, 16'h0455);
    do_scan(1'b0, lat, bm);
    chk2("lastwin_state", bus.state, 2'b00);
    chk2("lastwin_valid", bus.state_valid, 2'b10);
    clear_nodes();
    set_node(0, 16'h0234);
    do_scan(1'b0, lat, bm);
    chk2("nonleaf_state", bus.state, 2'b00);
    chk2("nonleaf_valid", bus.state_valid, 2'b00);
  endtask

  task automatic test_accumulate();
    int lat;
    logic bm;
    clear_nodes();
    set_node(3, 16'h0333);
    do_scan(1'b0, lat, bm);
    chk2("acc_first_state", bus.state, 2'b01);
    chk2("acc_first_valid", bus.state_valid, 2'b01);
    clear_nodes();
    set_node(6, 16'h0555);
    do_scan(1'b1, lat, bm);
    chk2("acc_state", bus.state, 2'b11);
    chk2("acc_valid", bus.state_valid, 2'b11);
    do_scan(1'b0, lat, bm);
    chk2("clr_state", bus.state, 2'b10);
    chk2("clr_valid", bus.state_valid, 2'b10);
  endtask

  task automatic test_ignored_inputs();
    int ndone = 0;
    clear_nodes();
    set_node(0, 16'h0333);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 1) set_node(0, 16'h0233);
      if (i == 3) bus.start = 1'b1;
      if (bus.done) ndone++;
    end
    chk_int("ignored_done_count", ndone, 1);
    chk2("ignored_state", bus.state, 2'b01);
    chk2("ignored_valid", bus.state_valid, 2'b01);
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone = 0;
    logic bm;
    clear_nodes();
    set_node(0, 16'h0333);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    nrst = 1'b0;
    @(negedge clk);
    chk2("rstmid_state", bus.state, 2'b00);
    chk2("rstmid_valid", bus.state_valid, 2'b00);
    chk_int("rstmid_busy", int'(bus.busy), 0);
    chk_int("rstmid_done", int'(bus.done), 0);
    nrst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk_int("rstmid_no_done", ndone, 0);
    clear_nodes();
    set_node(1, 16'h0333);
    set_node(4, 16'h0455);
    do_scan(1'b0, lat, bm);
    chk_int("fresh_latency", lat, 8);
    chk2("fresh_state", bus.state, 2'b01);
    chk2("fresh_valid", bus.state_valid, 2'b11);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_wins();
    test_accumulate();
    test_ignored_inputs();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
